mtl_timing_gen: RTL
===================

MTL_TIMING_GEN -- requirements
Module: mtl_timing_gen

Interface
REQ-001 SHALL have parameter H_SYNC, default 30, meaning hsync pulse width in pixel clocks.
REQ-002 SHALL have parameter H_BP, default 16, meaning horizontal back porch in pixel clocks.
REQ-003 SHALL have parameter H_ACTIVE, default 800, meaning visible pixels per line.
REQ-004 SHALL have parameter H_FP, default 210, meaning horizontal front porch in pixel clocks.
REQ-005 SHALL have parameter V_SYNC, default 13, meaning vsync pulse width in lines.
REQ-006 SHALL have parameter V_BP, default 10, meaning vertical back porch in lines.
REQ-007 SHALL have parameter V_ACTIVE, default 480, meaning visible lines per frame.
REQ-008 SHALL have parameter V_FP, default 22, meaning vertical front porch in lines.
REQ-009 SHALL have parameter PIPE_DLY, default 1, meaning extra cycles applied to hsync_n/vsync_n/de so they align with the downstream colour stage's registered RGB.
REQ-010 clk  in  1  single pixel clock; all logic on posedge.
REQ-011 reset_n  in  1  asynchronous, active-low reset.
REQ-012 en  in  1  pixel advance enable; counters and pipeline move only when high.
REQ-013 Xpos  out  11  active-area column, 0..H_ACTIVE-1; feeds colour stage.
REQ-014 Ypos  out  10  active-area row, 0..V_ACTIVE-1; feeds colour stage.
REQ-015 hsync_n  out  1  active-low horizontal sync, delayed by PIPE_DLY.
REQ-016 vsync_n  out  1  active-low vertical sync, delayed by PIPE_DLY.
REQ-017 de  out  1  data enable (active pixel), delayed by PIPE_DLY.
REQ-018 line_start  out  1  one-cycle pulse at start of each line (h_cnt==0).
REQ-019 frame_start  out  1  one-cycle pulse at h_cnt==0 and v_cnt==0.

Function
REQ-020 Internal h_cnt SHALL count 0..H_TOTAL-1 (H_TOTAL = sum of H_* = 1056 by default), +1 per en cycle, wrapping to 0.
REQ-021 Internal v_cnt SHALL increment only on h_cnt wrap, range 0..V_TOTAL-1 (525 default), wrapping to 0 when h_cnt and v_cnt both wrap in the same cycle.
REQ-022 Undelayed hsync SHALL be low while h_cnt < H_SYNC; vsync low while v_cnt < V_SYNC.
REQ-023 Undelayed active SHALL be high iff H_SYNC+H_BP <= h_cnt < H_SYNC+H_BP+H_ACTIVE and V_SYNC+V_BP <= v_cnt < V_SYNC+V_BP+V_ACTIVE.
REQ-024 Xpos/Ypos SHALL be registered: h_cnt-(H_SYNC+H_BP) and v_cnt-(V_SYNC+V_BP) when active, else 0; latency 1 cycle from counter state.
REQ-025 hsync_n/vsync_n/de SHALL equal the registered undelayed values further delayed by PIPE_DLY en-cycles (PIPE_DLY=0 means same cycle as Xpos/Ypos).
REQ-026 line_start/frame_start SHALL be registered with 1-cycle latency, same alignment as Xpos, and high for exactly one en cycle.
REQ-027 When en is low, counters, Xpos, Ypos, delay line and sync outputs SHALL hold; pulse outputs SHALL be 0.
REQ-028 Width arithmetic SHALL be unsigned; counter widths sized from H_TOTAL/V_TOTAL via $clog2; Xpos/Ypos truncated to port width.

Reset
REQ-029 On reset_n low, asynchronously: h_cnt=0, v_cnt=0, Xpos=0, Ypos=0, hsync_n=1, vsync_n=1, de=0, line_start=0, frame_start=0, delay line cleared to inactive.
REQ-030 Reset asserted mid-frame SHALL abort the frame; first en cycle after release starts at h_cnt=0, v_cnt=0 and produces frame_start.

Structure
REQ-031 Default timing constants and derived H_TOTAL/V_TOTAL SHALL live in shared package mtl_pkg.
REQ-032 Sync/de delay SHALL be sub-module sync_delay (parameterised width/depth shift register with en and async reset_n).

Verification
REQ-033 Reset release, en=1 constantly: frame_start after 1 cycle, next frame_start exactly 1056*525=554400 cycles later.
REQ-034 Line check: hsync_n low for 30 cycles, de high for 800 cycles starting PIPE_DLY cycles after Xpos=0, Xpos ramps 0..799 then 0.
REQ-035 Frame check: vsync_n low for 13 lines; de asserted on 480 lines; Ypos 0 at v_cnt=23, 479 at v_cnt=502.
REQ-036 en toggled 1/0 alternately: all timings double in clk cycles, pulses remain one cycle wide, no output change on en=0 cycles.
REQ-037 reset_n pulsed low at Xpos=400,Ypos=200: outputs go to reset values immediately; restart at frame_start.
REQ-038 PIPE_DLY=0 and 3: de rising edge offset from Xpos=0 by 0 and 3 cycles respectively.

Source files
------------

// File: rtl/mtl_pkg.sv
// Shared timing defaults and helpers for the mtl display timing generator.
package mtl_pkg;

  // Default 800x480 panel timing (pixel clocks / lines)
  localparam int H_SYNC_DEF   = 30;
  localparam int H_BP_DEF     = 16;
  localparam int H_ACTIVE_DEF = 800;
  localparam int H_FP_DEF     = 210;
  localparam int V_SYNC_DEF   = 13;
  localparam int V_BP_DEF     = 10;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 22;
  localparam int PIPE_DLY_DEF = 1;

  localparam int H_TOTAL = H_SYNC_DEF + H_BP_DEF + H_ACTIVE_DEF + H_FP_DEF;
  localparam int V_TOTAL = V_SYNC_DEF + V_BP_DEF + V_ACTIVE_DEF + V_FP_DEF;

  // Sync/de bundle carried through the alignment delay line
  typedef struct packed {
    logic hsync_n;
    logic vsync_n;
    logic de;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{hsync_n: 1'b1, vsync_n: 1'b1, de: 1'b0};

  // Counter width able to hold 0..total-1 (never narrower than one bit)
  function automatic int cnt_w(input int total);
    return (total > 1) ? $clog2(total) : 1;
  endfunction

endpackage

// File: rtl/sync_delay.sv
// Enabled shift register of configurable width/depth; depth 0 is a wire.
module sync_delay #(
  parameter int               WIDTH   = 3,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic unused_ctrl;
      assign unused_ctrl = ^{clk, reset_n, en};
      assign dout = din;
    end else begin : g_shift
      logic [WIDTH-1:0] sr_p [DEPTH];

      // Advance one stage per enabled cycle; reset fills every stage with the idle pattern
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int i = 0; i < DEPTH; i++) sr_p[i] <= RST_VAL;
        end else if (en) begin
          sr_p[0] <= din;
          for (int i = 1; i < DEPTH; i++) sr_p[i] <= sr_p[i-1];
        end
      end

      assign dout = sr_p[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/mtl_timing_gen.sv
// Display timing generator: h/v counters, registered active-area coordinates,
// line/frame pulses, and sync/de delayed to line up with the colour stage.
module mtl_timing_gen
  import mtl_pkg::*;
#(
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int PIPE_DLY = PIPE_DLY_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  output logic [10:0] Xpos,
  output logic [9:0]  Ypos,
  output logic        hsync_n,
  output logic        vsync_n,
  output logic        de,
  output logic        line_start,
  output logic        frame_start
);

  localparam int H_TOT  = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOT  = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int HW     = cnt_w(H_TOT);
  localparam int VW     = cnt_w(V_TOT);
  localparam int H_ACT0 = H_SYNC + H_BP;
  localparam int H_ACT1 = H_ACT0 + H_ACTIVE;
  localparam int V_ACT0 = V_SYNC + V_BP;
  localparam int V_ACT1 = V_ACT0 + V_ACTIVE;

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_wrap;
  logic          v_wrap;
  logic          h_act;
  logic          v_act;
  logic          hs_n;
  logic          vs_n;
  sync_t         sync_p0;
  sync_t         sync_dly;

  // Decode counter state: wrap points, active window, undelayed syncs
  always_comb begin
    h_wrap = (32'(h_cnt) == H_TOT - 1);
    v_wrap = (32'(v_cnt) == V_TOT - 1);
    h_act  = (32'(h_cnt) >= H_ACT0) && (32'(h_cnt) < H_ACT1);
    v_act  = (32'(v_cnt) >= V_ACT0) && (32'(v_cnt) < V_ACT1);
    hs_n   = !(32'(h_cnt) < H_SYNC);
    vs_n   = !(32'(v_cnt) < V_SYNC);
  end

  // Pixel/line counters; v_cnt steps only when the line wraps
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (en) begin
      if (h_wrap) begin
        h_cnt <= '0;
        v_cnt <= v_wrap ? '0 : v_cnt + VW'(1);
      end else begin
        h_cnt <= h_cnt + HW'(1);
      end
    end
  end

  // Stage p0: coordinates, pulses and undelayed sync bundle, one cycle after the counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      Xpos        <= '0;
      Ypos        <= '0;
      sync_p0     <= SYNC_IDLE;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= en && (h_cnt == '0);
      frame_start <= en && (h_cnt == '0) && (v_cnt == '0);
      if (en) begin
        Xpos    <= (h_act && v_act) ? 11'(h_cnt - HW'(H_ACT0)) : '0;
        Ypos    <= (h_act && v_act) ? 10'(v_cnt - VW'(V_ACT0)) : '0;
        sync_p0 <= '{hsync_n: hs_n, vsync_n: vs_n, de: h_act && v_act};
      end
    end
  end

  // Stage p1..pN: align sync/de with the downstream registered RGB
  sync_delay #(
    .WIDTH  ($bits(sync_t)),
    .DEPTH  (PIPE_DLY),
    .RST_VAL(SYNC_IDLE)
  ) u_sync_delay (
    .clk    (clk),
    .reset_n(reset_n),
    .en     (en),
    .din    (sync_p0),
    .dout   (sync_dly)
  );

  assign hsync_n = sync_dly.hsync_n;
  assign vsync_n = sync_dly.vsync_n;
  assign de      = sync_dly.de;

endmodule
